// File: rtl/bcd_pkg.sv
// bcd_pkg: FSM encodings, double-dabble adjust constants and clog2 helper shared by the BCD converter.
package bcd_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bcd_shift_core.sv
// bcd_shift_core: serial double-dabble datapath, one add-3 adjust and one-bit shift per enabled clock.
module bcd_shift_core
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry_out
);
  logic [WIDTH-1:0]    shf;
  logic [4*DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= BCD_ADJ_THRESH ? bcd[4*i +: 4] + BCD_ADJ_ADD : bcd[4*i +: 4];
  end
  // The adjusted top bit is what leaves the digit register on this shift.
  assign carry_out = adj[4*DIGITS-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= '0;
      shf <= '0;
    end else if (load) begin
      bcd <= '0;
      shf <= bin_in;
    end else if (en) begin
      bcd <= {adj[4*DIGITS-2:0], shf[WIDTH-1]};
      shf <= shf << 1;
    end
  end
endmodule

// File: rtl/bcd_convert_sched.sv
// bcd_convert_sched: round-robin shared binary-to-BCD converter; optional BCD_OVERFLOW_EN adds saturation and ovf.
module bcd_convert_sched
  import bcd_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int WIDTH   = 8,
  parameter  int DIGITS  = 3,
  localparam int IW      = clog2(NUM_REQ),
  localparam int CW      = clog2(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] bin,
  output logic [NUM_REQ-1:0]       ack,
  output logic [4*DIGITS-1:0]      bcd,
  output logic [IW-1:0]            res_id,
  output logic                     busy
`ifdef BCD_OVERFLOW_EN
  ,
  output logic                     ovf
`endif
);
  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       ptr, id, gnt;
  logic [4*DIGITS-1:0] core_bcd, done_bcd, bcd_r;
  logic                load, en, last, carry;
  assign load = state == S_IDLE && |req;
  assign en   = state == S_SHIFT;
  assign last = cnt == CW'(WIDTH - 1);
  // Walk from the farthest offset down so the nearest set request at or after ptr wins.
  always_comb begin
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int p;
      p = int'(ptr) + k;
      p = p >= NUM_REQ ? p - NUM_REQ : p;
      if (req[p]) gnt = IW'(p);
    end
  end
  bcd_shift_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (en),
    .bin_in    (bin[gnt*WIDTH +: WIDTH]),
    .bcd       (core_bcd),
    .carry_out (carry)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ptr    <= '0;
      id     <= '0;
      res_id <= '0;
      bcd_r  <= '0;
    end else if (state == S_IDLE) begin
      if (|req) begin
        state <= S_SHIFT;
        id    <= gnt;
        cnt   <= '0;
      end
    end else if (state == S_SHIFT) begin
      cnt <= cnt + CW'(1);
      if (last) begin
        state  <= S_DONE;
        res_id <= id;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
      ptr   <= id == IW'(NUM_REQ - 1) ? '0 : id + IW'(1);
      bcd_r <= done_bcd;
    end else begin
      state <= S_IDLE;
    end
  end
`ifdef BCD_OVERFLOW_EN
  logic sticky;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      sticky <= 1'b0;
      ovf    <= 1'b0;
    end else if (en) begin
      sticky <= sticky | carry;
      if (last) ovf <= sticky | carry;
    end
  end
  assign done_bcd = ovf ? {DIGITS{4'h9}} : core_bcd;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign done_bcd     = core_bcd;
`endif
  // Result is live from the core during DONE, then held from bcd_r while idle.
  assign bcd  = state == S_DONE ? done_bcd : bcd_r;
  assign ack  = state == S_DONE ? NUM_REQ'(1) << id : '0;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_bcd_convert_sched.sv
// tb_bcd_convert_sched: directed and randomized checks of the shared BCD converter against a decimal reference model.
module tb_bcd_convert_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] bin = '0;
  logic [2:0]  ack;
  logic [11:0] bcd;
  logic [1:0]  res_id;
  logic        busy;
  logic [2:0]  req_b = '0;
  logic [23:0] bin_b = '0;
  logic [2:0]  ack_b;
  logic [7:0]  bcd_b;
  logic [1:0]  res_id_b;
  logic        busy_b;
`ifdef BCD_OVERFLOW_EN
  logic        ovf_a, ovf_b;
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  int n = 0, errs = 0, cyc = 0, mptr = 0;
  int c, c2, n0, exp_id;
  bit got, seen;
  logic [31:0] rnd;
  int t_q[$];
  bcd_convert_sched #(.NUM_REQ(3), .WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .req(req), .bin(bin), .ack(ack), .bcd(bcd), .res_id(res_id), .busy(busy)
`ifdef BCD_OVERFLOW_EN
    , .ovf(ovf_a)
`endif
  );
  bcd_convert_sched #(.NUM_REQ(3), .WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .req(req_b), .bin(bin_b), .ack(ack_b), .bcd(bcd_b), .res_id(res_id_b), .busy(busy_b)
`ifdef BCD_OVERFLOW_EN
    , .ovf(ovf_b)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [19:0] ref_bcd(input int v, input int d, input bit sat);
    int m, x;
    logic [19:0] r;
    m = 1;
    for (int i = 0; i < d; i++) m *= 10;
    r = '0;
    x = (sat && v >= m) ? m - 1 : v % m;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x /= 10;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    chk(tag, busy, 1);
  endtask
  // Requesters in m hold req until acked; the expected winner is the nearest pending index at or after mptr.
  task automatic serve_mask(input logic [2:0] m, input logic [23:0] b, input string tag);
    logic [2:0] pend;
    int k, e;
    bit f;
    pend = m;
    bin  = b;
    req  = m;
    while (pend != 0) begin
      e = 0;
      f = 0;
      for (int j = 0; j < 3; j++)
        if (!f && pend[(mptr + j) % 3]) begin
          e = (mptr + j) % 3;
          f = 1;
        end
      k = 0;
      while (ack == 0 && k < 40) begin
        tick();
        k++;
      end
      t_q.push_back(cyc);
      chk($sformatf("%s_ack", tag), ack, 32'(1) << e);
      chk($sformatf("%s_bcd", tag), bcd, ref_bcd(int'(b[e*8 +: 8]), 3, SAT));
      chk($sformatf("%s_id", tag), res_id, e);
`ifdef BCD_OVERFLOW_EN
      chk($sformatf("%s_ovf", tag), ovf_a, 0);
`endif
      pend    = ack == 0 ? '0 : pend & ~(3'(1) << e);
      req     = pend;
      mptr    = (e + 1) % 3;
      tick();
      chk($sformatf("%s_pulse", tag), ack, 0);
    end
  endtask
  task automatic serve_b(input logic [7:0] v, input string tag);
    int k;
    bin_b[7:0] = v;
    req_b = 3'b001;
    k = 0;
    while (!ack_b[0] && k < 40) begin
      tick();
      k++;
    end
    chk($sformatf("%s_ack", tag), ack_b, 3'b001);
    chk($sformatf("%s_bcd", tag), bcd_b, ref_bcd(int'(v), 2, SAT));
`ifdef BCD_OVERFLOW_EN
    chk($sformatf("%s_ovf", tag), ovf_b, int'(v) > 99);
`endif
    req_b = '0;
    tick();
  endtask
  initial begin
    tick();
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_bcd", bcd, 0);
    chk("reset_id", res_id, 0);
    rst = 1'b0;
    tick();
    // T2: single request, latency counted from req presentation in IDLE (capture edge included)
    bin[15:8] = 8'd255;
    req = 3'b010;
    c = 0;
    while (!ack[1] && c < 40) begin
      tick();
      c++;
    end
    chk("t2_latency", c, 9);
    chk("t2_ack", ack, 3'b010);
    chk("t2_bcd", bcd, 12'h255);
    chk("t2_id", res_id, 1);
    req = '0;
    tick();
    chk("t2_hold_bcd", bcd, 12'h255);
    mptr = 2;
    serve_mask(3'b010, 24'h0, "t2_zero");
    // T1: reset in the middle of SHIFT
    bin[15:8] = 8'd77;
    req = 3'b010;
    wait_busy("t1_start");
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t1_ack", ack, 0);
    chk("t1_busy", busy, 0);
    chk("t1_bcd", bcd, 0);
    req = '0;
    #2 rst = 1'b0;
    tick();
    mptr = 0;
    serve_mask(3'b011, {8'd0, 8'd45, 8'd6}, "t1_after");
    // T3: full contention from a clean pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mptr = 0;
    t_q.delete();
    serve_mask(3'b111, {8'd99, 8'd128, 8'd17}, "t3");
    chk("t3_gap01", t_q[1] - t_q[0], 10);
    chk("t3_gap12", t_q[2] - t_q[1], 10);
    // T4: req0 held permanently, req2 arrives mid-conversion
    bin = {8'd7, 8'd0, 8'd42};
    req = 3'b001;
    wait_busy("t4_start");
    tick();
    tick();
    req[2] = 1'b1;
    n0 = 0;
    got = 0;
    c = 0;
    while (!got && c < 60) begin
      tick();
      c++;
      if (ack[0]) n0++;
      if (ack[2]) begin
        got = 1;
        chk("t4_bcd", bcd, 12'h007);
      end
    end
    req = '0;
    chk("t4_served", got, 1);
    chk("t4_wait", n0 <= 1, 1);
    tick();
    tick();
    mptr = 0;
    // T6: req0 drops two cycles after capture
    bin[7:0] = 8'd123;
    req = 3'b001;
    wait_busy("t6_start");
    tick();
    tick();
    req = '0;
    c2 = 0;
    while (!ack[0] && c2 < 40) begin
      tick();
      c2++;
    end
    chk("t6_latency", c2, 6);
    chk("t6_bcd", bcd, 12'h123);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= busy;
    end
    chk("t6_no_regrant", seen, 0);
    mptr = 1;
    // Randomized contention rounds
    for (int r = 0; r < 12; r++) begin
      rnd = $urandom;
      serve_mask(3'($urandom_range(1, 7)), rnd[23:0], "rr");
    end
    // Every operand on requester 0
    for (int v = 0; v < 256; v++) serve_mask(3'b001, {16'h0, 8'(v)}, "exh");
    // T5: two-digit instance, overflow behaviour
    serve_b(8'd200, "t5_200");
    serve_b(8'd99, "t5_99");
    serve_b(8'd100, "t5_100");
    for (int r = 0; r < 6; r++) serve_b(8'($urandom_range(0, 255)), "t5_rnd");
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
